// File: rtl/router_pkt_framer.sv
// ============================================================================
// router_pkt_framer : buffers a full payload, then emits header/payload/parity
//                     bytes to the 1x3 router input. Optional: PARITY_CORRUPT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module router_pkt_framer #(
  parameter int NUM_PORTS = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  input  logic [1:0]       cmd_addr_i,
  input  logic [5:0]       cmd_len_i,
`ifdef PARITY_CORRUPT_EN
  input  logic             corrupt_parity_i,
`endif
  output logic             cmd_ready_o,
  output logic             cmd_err_o,
  input  logic [7:0]       pl_data_i,
  input  logic             pl_valid_i,
  output logic             pl_ready_o,
  input  logic             busy_i,
  output logic [7:0]       pkt_data_o,
  output logic             pkt_valid_o,
  output logic             frm_active_o,
  output logic             pkt_done_o,
  output logic [CNT_W-1:0] pkt_count_o
);

  localparam logic [2:0] c_PORT_LIMIT = 3'(NUM_PORTS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4
  } state_t;

  state_t           state_q;
  logic [7:0]       mem_q [64];
  logic [1:0]       addr_q;
  logic [5:0]       len_q;
  logic [5:0]       wr_cnt_q;
  logic [5:0]       rd_cnt_q;
  logic [7:0]       parity_q;
  logic [7:0]       pkt_data_q;
  logic             pkt_valid_q;
  logic             frm_active_q;
  logic             cmd_err_q;
  logic             pkt_done_q;
  logic [CNT_W-1:0] pkt_count_q;

  logic       w_cmd_bad;
  logic [7:0] w_header;
  logic [5:0] w_last;
  logic [7:0] w_parity_out;

  assign w_cmd_bad = ({1'b0, cmd_addr_i} >= c_PORT_LIMIT) || (cmd_len_i == 6'd0);
  assign w_header  = {len_q, addr_q};
  assign w_last    = len_q - 6'd1;

`ifdef PARITY_CORRUPT_EN
  logic corrupt_q;
  assign w_parity_out = parity_q ^ {8{corrupt_q}};
`else
  assign w_parity_out = parity_q;
`endif

  // Payload store has no reset: contents are meaningless until refilled.
  always_ff @(posedge clock_i) begin
    if (state_q == S_FILL && pl_valid_i) begin
      mem_q[wr_cnt_q] <= pl_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      addr_q       <= 2'd0;
      len_q        <= 6'd0;
      wr_cnt_q     <= 6'd0;
      rd_cnt_q     <= 6'd0;
      parity_q     <= 8'd0;
      pkt_data_q   <= 8'd0;
      pkt_valid_q  <= 1'b0;
      frm_active_q <= 1'b0;
      cmd_err_q    <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_count_q  <= '0;
`ifdef PARITY_CORRUPT_EN
      corrupt_q    <= 1'b0;
`endif
    end else begin
      cmd_err_q  <= 1'b0;
      pkt_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (w_cmd_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              addr_q   <= cmd_addr_i;
              len_q    <= cmd_len_i;
              parity_q <= 8'd0;
              wr_cnt_q <= 6'd0;
              state_q  <= S_FILL;
`ifdef PARITY_CORRUPT_EN
              corrupt_q <= corrupt_parity_i;
`endif
            end
          end
        end
        S_FILL: begin
          if (pl_valid_i) begin
            wr_cnt_q <= wr_cnt_q + 6'd1;
            // Header is folded into parity here so it is final before PAYLOAD.
            if (wr_cnt_q == w_last) begin
              parity_q     <= parity_q ^ pl_data_i ^ w_header;
              pkt_data_q   <= w_header;
              pkt_valid_q  <= 1'b1;
              frm_active_q <= 1'b1;
              state_q      <= S_HEADER;
            end else begin
              parity_q <= parity_q ^ pl_data_i;
            end
          end
        end
        S_HEADER: begin
          if (!busy_i) begin
            rd_cnt_q   <= 6'd0;
            pkt_data_q <= mem_q[6'd0];
            state_q    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!busy_i) begin
            rd_cnt_q <= rd_cnt_q + 6'd1;
            if (rd_cnt_q == w_last) begin
              pkt_valid_q <= 1'b0;
              pkt_data_q  <= w_parity_out;
              state_q     <= S_PARITY;
            end else begin
              pkt_data_q <= mem_q[rd_cnt_q + 6'd1];
            end
          end
        end
        S_PARITY: begin
          if (!busy_i) begin
            pkt_data_q   <= 8'd0;
            frm_active_q <= 1'b0;
            pkt_done_q   <= 1'b1;
            pkt_count_q  <= pkt_count_q + CNT_W'(1);
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign pl_ready_o   = (state_q == S_FILL);
  assign cmd_err_o    = cmd_err_q;
  assign pkt_data_o   = pkt_data_q;
  assign pkt_valid_o  = pkt_valid_q;
  assign frm_active_o = frm_active_q;
  assign pkt_done_o   = pkt_done_q;
  assign pkt_count_o  = pkt_count_q;

endmodule

`default_nettype wire

// File: tb/tb_router_pkt_framer.sv
// ============================================================================
// tb_router_pkt_framer : randomized bench for router_pkt_framer against a
//                        packet-level model. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_router_pkt_framer;

`ifdef PARITY_CORRUPT_EN
  localparam bit CORRUPT_ON = 1'b1;
`else
  localparam bit CORRUPT_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_addr = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic        corrupt_parity = 1'b0;
  logic [7:0]  pl_data = 8'd0;
  logic        pl_valid = 1'b0;
  logic        busy = 1'b0;
  logic        cmd_ready, cmd_err, pl_ready, pkt_valid, frm_active, pkt_done;
  logic [7:0]  pkt_data;
  logic [15:0] pkt_count;

  int total = 0;
  int bad = 0;
  int exp_count = 0;

  logic [7:0] pl_buf [64];
  logic [7:0] exp_q [$];
  logic [7:0] obs_got [$];
  logic       obs_gotv [$];
  logic [7:0] obs_held [$];
  int         obs_hold_bad, obs_feed_bad;
  bit         obs_tmo;
  logic       obs_rdy, obs_done, obs_rdy_after, obs_hdr_valid, obs_hdr_active;
  logic [7:0] obs_hdr_data;
  logic [15:0] obs_count;

  router_pkt_framer #(.NUM_PORTS(3), .CNT_W(16)) dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .cmd_valid_i      (cmd_valid),
    .cmd_addr_i       (cmd_addr),
    .cmd_len_i        (cmd_len),
`ifdef PARITY_CORRUPT_EN
    .corrupt_parity_i (corrupt_parity),
`endif
    .cmd_ready_o      (cmd_ready),
    .cmd_err_o        (cmd_err),
    .pl_data_i        (pl_data),
    .pl_valid_i       (pl_valid),
    .pl_ready_o       (pl_ready),
    .busy_i           (busy),
    .pkt_data_o       (pkt_data),
    .pkt_valid_o      (pkt_valid),
    .frm_active_o     (frm_active),
    .pkt_done_o       (pkt_done),
    .pkt_count_o      (pkt_count)
  );

  always #5 clock = ~clock;

  // Packet model: header {len,addr}, payload, then XOR of everything sent.
  task automatic build_exp(input logic [1:0] a, input int len, input logic cp);
    logic [7:0] p;
    exp_q.delete();
    exp_q.push_back({6'(len), a});
    for (int i = 0; i < len; i++) exp_q.push_back(pl_buf[i]);
    p = 8'd0;
    foreach (exp_q[i]) p = p ^ exp_q[i];
    if (cp && CORRUPT_ON) p = ~p;
    exp_q.push_back(p);
  endtask

  function automatic int stream_errs();
    int e = 0;
    if (obs_got.size() != exp_q.size()) e++;
    for (int i = 0; i < exp_q.size() && i < obs_got.size(); i++) begin
      if (obs_got[i] !== exp_q[i]) e++;
      if (obs_gotv[i] !== (i < exp_q.size() - 1)) e++;
    end
    return e;
  endfunction

  task automatic issue_cmd(input logic [1:0] a, input logic [5:0] l, input logic cp, output logic rdy_seen);
    rdy_seen = cmd_ready;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; corrupt_parity = cp;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_addr = 2'($urandom); cmd_len = 6'($urandom);
    corrupt_parity = 1'($urandom);
  endtask

  task automatic feed(input int len, input int gap, input bit rand_gap, output int fbad);
    int g;
    fbad = 0;
    for (int i = 0; i < len; i++) begin
      g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
      for (int k = 0; k < g; k++) begin
        pl_valid = 1'b0; pl_data = 8'($urandom); busy = 1'($urandom);
        cmd_valid = 1'($urandom); cmd_addr = 2'($urandom_range(2, 0)); cmd_len = 6'($urandom_range(63, 1));
        if (frm_active || !pl_ready) fbad++;
        @(negedge clock);
      end
      pl_valid = 1'b1; pl_data = pl_buf[i]; busy = 1'($urandom);
      if (frm_active || !pl_ready) fbad++;
      @(negedge clock);
    end
    pl_valid = 1'b0; pl_data = 8'($urandom); cmd_valid = 1'b0;
  endtask

  task automatic drain(input int len, input int busy_pct, input int stall_at, input int stall_len, input int stop_after);
    logic pb = 1'b0, pa = 1'b0, pv = 1'b0;
    logic [7:0] pd = 8'd0;
    int sc = 0;
    int cyc = 0;
    obs_got.delete(); obs_gotv.delete(); obs_held.delete();
    obs_hold_bad = 0; obs_tmo = 1'b0;
    while (obs_got.size() < len + 2 && obs_got.size() != stop_after && !obs_tmo) begin
      if (cyc >= 3000) begin
        obs_tmo = 1'b1;
      end else begin
        if (pb && pa && (pkt_data !== pd || pkt_valid !== pv)) obs_hold_bad++;
        if (obs_got.size() == stall_at && sc < stall_len) begin
          busy = 1'b1; sc++; obs_held.push_back(pkt_data);
        end else begin
          busy = ($urandom_range(99, 0) < busy_pct);
        end
        if (frm_active && !busy) begin
          obs_got.push_back(pkt_data); obs_gotv.push_back(pkt_valid);
        end
        pb = busy; pa = frm_active; pd = pkt_data; pv = pkt_valid;
        @(negedge clock);
        cyc++;
      end
    end
  endtask

  task automatic run_packet(input logic [1:0] a, input int len, input logic cp, input int gap, input bit rand_gap,
                            input int busy_pct, input int stall_at, input int stall_len, input int stop_after);
    issue_cmd(a, 6'(len), cp, obs_rdy);
    feed(len, gap, rand_gap, obs_feed_bad);
    obs_hdr_data = pkt_data; obs_hdr_valid = pkt_valid; obs_hdr_active = frm_active;
    drain(len, busy_pct, stall_at, stall_len, stop_after);
    obs_done = pkt_done; obs_count = pkt_count; obs_rdy_after = cmd_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    total++; if ({pkt_valid, frm_active, cmd_err, pkt_done} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got=%b want=0000", {pkt_valid, frm_active, cmd_err, pkt_done}); end
    total++; if (pkt_data !== 8'h00) begin bad++; $display("FAIL reset_data: got=%h want=00", pkt_data); end
    total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_count: got=%0d want=0", pkt_count); end
    total++; if ({cmd_ready, pl_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_ready: got=%b want=10", {cmd_ready, pl_ready}); end
  endtask

  task automatic test_cmd_err();
    logic r;
    issue_cmd(2'd3, 6'd4, 1'b0, r);
    total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_addr: got=%b want=1", cmd_err); end
    total++; if ({cmd_ready, pl_ready, frm_active} !== 3'b100) begin
      bad++; $display("FAIL err_stay_idle: got=%b want=100", {cmd_ready, pl_ready, frm_active}); end
    @(negedge clock);
    total++; if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_pulse: got=%b want=0", cmd_err); end
    issue_cmd(2'd0, 6'd0, 1'b0, r);
    total++; if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_len0: got=%b want=1", cmd_err); end
    @(negedge clock);
    total++; if ({pl_ready, pkt_count} !== {1'b0, 16'd0}) begin
      bad++; $display("FAIL err_count: pl_ready=%b count=%0d want 0/0", pl_ready, pkt_count); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) pl_buf[i] = 8'(i + 1);
    build_exp(2'd1, 16, 1'b0);
    run_packet(2'd1, 16, 1'b0, 0, 1'b0, 0, -1, 0, -1);
    exp_count++;
    total++; if ({obs_hdr_active, obs_hdr_valid, obs_hdr_data} !== {2'b11, 8'h41}) begin
      bad++; $display("FAIL basic_header: got=%h v=%b want=41 v=1", obs_hdr_data, obs_hdr_valid); end
    total++; if (stream_errs() != 0 || obs_tmo) begin
      bad++; $display("FAIL basic_stream: errs=%0d size=%0d want 0/18", stream_errs(), obs_got.size()); end
    total++; if (obs_got[17] !== 8'h51) begin bad++; $display("FAIL basic_parity: got=%h want=51", obs_got[17]); end
    total++; if ({obs_done, obs_rdy_after, obs_count} !== {2'b11, 16'(exp_count)}) begin
      bad++; $display("FAIL basic_done: done=%b rdy=%b count=%0d want 1/1/%0d", obs_done, obs_rdy_after, obs_count, exp_count); end
    @(negedge clock);
    total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got=%b want=0", pkt_done); end
  endtask

  task automatic test_busy_stall();
    build_exp(2'd1, 16, 1'b0);
    run_packet(2'd1, 16, 1'b0, 0, 1'b0, 0, 5, 3, -1);
    exp_count++;
    total++; if (obs_held.size() != 3 || obs_held[0] !== 8'h05 || obs_held[1] !== 8'h05 || obs_held[2] !== 8'h05) begin
      bad++; $display("FAIL stall_held: n=%0d first=%h want 3 x 05", obs_held.size(), obs_held[0]); end
    total++; if (obs_hold_bad != 0) begin bad++; $display("FAIL stall_hold: changes=%0d want 0", obs_hold_bad); end
    total++; if (obs_got[5] !== 8'h05 || obs_got[6] !== 8'h06 || obs_got.size() != 18) begin
      bad++; $display("FAIL stall_order: b5=%h b6=%h n=%0d want 05 06 18", obs_got[5], obs_got[6], obs_got.size()); end
    total++; if (stream_errs() != 0 || obs_count !== 16'(exp_count)) begin
      bad++; $display("FAIL stall_stream: errs=%0d count=%0d want 0/%0d", stream_errs(), obs_count, exp_count); end
  endtask

  task automatic test_pl_gaps();
    for (int i = 0; i < 4; i++) pl_buf[i] = 8'($urandom);
    build_exp(2'd2, 4, 1'b0);
    run_packet(2'd2, 4, 1'b0, 2, 1'b0, 40, -1, 0, -1);
    exp_count++;
    total++; if (obs_feed_bad != 0) begin bad++; $display("FAIL gaps_early: violations=%0d want 0", obs_feed_bad); end
    total++; if ({obs_hdr_active, obs_hdr_valid, obs_hdr_data} !== {2'b11, 8'h12}) begin
      bad++; $display("FAIL gaps_hdr_latency: got=%h a=%b want=12 a=1", obs_hdr_data, obs_hdr_active); end
    total++; if (stream_errs() != 0 || obs_hold_bad != 0 || obs_count !== 16'(exp_count)) begin
      bad++; $display("FAIL gaps_stream: errs=%0d hold=%0d count=%0d want 0/0/%0d", stream_errs(), obs_hold_bad, obs_count, exp_count); end
  endtask

  task automatic test_single_byte();
    pl_buf[0] = 8'hFF;
    run_packet(2'd2, 1, 1'b0, 0, 1'b0, 0, -1, 0, -1);
    exp_count++;
    total++; if (obs_got.size() != 3 || obs_got[0] !== 8'h06 || obs_got[1] !== 8'hFF || obs_got[2] !== 8'hF9) begin
      bad++; $display("FAIL single_stream: %h %h %h want 06 ff f9", obs_got[0], obs_got[1], obs_got[2]); end
`ifdef PARITY_CORRUPT_EN
    run_packet(2'd2, 1, 1'b1, 0, 1'b0, 0, -1, 0, -1);
    exp_count++;
    total++; if (obs_got[2] !== 8'h06 || obs_rdy !== 1'b1) begin
      bad++; $display("FAIL corrupt_parity: got=%h rdy=%b want 06 1", obs_got[2], obs_rdy); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] a;
    int len;
    logic cp;
    int errs = 0;
    for (int p = 0; p < 8; p++) begin
      a = 2'($urandom_range(2, 0));
      len = (p == 0) ? 63 : int'($urandom_range(63, 1));
      cp = 1'($urandom);
      for (int i = 0; i < len; i++) pl_buf[i] = 8'($urandom);
      build_exp(a, len, cp);
      run_packet(a, len, cp, 2, 1'b1, 30, -1, 0, -1);
      exp_count++;
      if (stream_errs() != 0 || obs_hold_bad != 0 || obs_feed_bad != 0 || obs_tmo) errs++;
      total++; if ({obs_rdy, obs_done, obs_rdy_after, obs_count} !== {3'b111, 16'(exp_count)}) begin
        bad++; $display("FAIL b2b_handshake[%0d]: rdy=%b done=%b idle=%b count=%0d want 1/1/1/%0d",
                        p, obs_rdy, obs_done, obs_rdy_after, obs_count, exp_count); end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL b2b_stream: bad_packets=%0d want 0", errs); end
  endtask

  task automatic test_midpkt_reset();
    for (int i = 0; i < 12; i++) pl_buf[i] = 8'($urandom);
    run_packet(2'd0, 12, 1'b0, 0, 1'b0, 0, -1, 0, 7);
    total++; if ({frm_active, pkt_valid, pkt_data} !== {2'b11, pl_buf[6]}) begin
      bad++; $display("FAIL rst_setup: got=%h a=%b want=%h a=1", pkt_data, frm_active, pl_buf[6]); end
    reset = 1'b1; busy = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_count = 0;
    total++; if ({pkt_valid, frm_active, cmd_ready, pkt_count} !== {3'b001, 16'd0}) begin
      bad++; $display("FAIL rst_abort: v=%b a=%b rdy=%b count=%0d want 0/0/1/0", pkt_valid, frm_active, cmd_ready, pkt_count); end
    pl_buf[0] = 8'($urandom);
    build_exp(2'd1, 1, 1'b0);
    run_packet(2'd1, 1, 1'b0, 0, 1'b0, 20, -1, 0, -1);
    exp_count++;
    total++; if (stream_errs() != 0 || obs_count !== 16'(exp_count) || obs_done !== 1'b1) begin
      bad++; $display("FAIL rst_recover: errs=%0d count=%0d done=%b want 0/1/1", stream_errs(), obs_count, obs_done); end
  endtask

  initial begin
    test_reset();
    test_cmd_err();
    test_basic();
    test_busy_stall();
    test_pl_gaps();
    test_single_byte();
    test_back_to_back();
    test_midpkt_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
